// File: rtl/adma_desc_queue.sv
`default_nettype none
// ============================================================================
//  Module   : adma_desc_queue
//  Purpose  : Per-channel descriptor FIFO between the CSR block and the channel
//             transfer engine. Stores pushed descriptors, issues them in order
//             one at a time, tracks per-slot completion and optionally
//             re-queues completed descriptors (cyclic mode).
//  Revision : 1.0  initial release
// ============================================================================
module adma_desc_queue #(
  parameter int SRC_ADDR_W     = 32,
  parameter int DST_ADDR_W     = 32,
  parameter int DMA_LENGTH_W   = 16,
  parameter int DMA_DESC_DEPTH = 4,
  parameter int DMA_XFER_ID_W  = $clog2(DMA_DESC_DEPTH)
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      chn_en_i,
  input  logic                      chn_cyclic_i,
  input  logic                      desc_wr_vld_i,
  output logic                      desc_wr_rdy_o,
  input  logic [SRC_ADDR_W-1:0]     desc_src_addr_i,
  input  logic [DST_ADDR_W-1:0]     desc_dst_addr_i,
  input  logic [DMA_LENGTH_W-1:0]   desc_xlen_i,
  input  logic [DMA_LENGTH_W-1:0]   desc_ylen_i,
  input  logic [DMA_LENGTH_W-1:0]   desc_src_strd_i,
  input  logic [DMA_LENGTH_W-1:0]   desc_dst_strd_i,
  output logic                      desc_rd_vld_o,
  input  logic                      desc_rd_rdy_i,
  output logic [DMA_XFER_ID_W-1:0]  desc_rd_id_o,
  output logic [SRC_ADDR_W-1:0]     desc_rd_src_addr_o,
  output logic [DST_ADDR_W-1:0]     desc_rd_dst_addr_o,
  output logic [DMA_LENGTH_W-1:0]   desc_rd_xlen_o,
  output logic [DMA_LENGTH_W-1:0]   desc_rd_ylen_o,
  output logic [DMA_LENGTH_W-1:0]   desc_rd_src_strd_o,
  output logic [DMA_LENGTH_W-1:0]   desc_rd_dst_strd_o,
  input  logic                      xfer_cpl_i,
  output logic [DMA_XFER_ID_W-1:0]  xfer_id_o,
  output logic [DMA_DESC_DEPTH-1:0] xfer_done_o,
  output logic [DMA_XFER_ID_W-1:0]  active_xfer_id_o,
  output logic [DMA_LENGTH_W-1:0]   active_xfer_len_o,
  output logic                      irq_qed_o,
  output logic                      irq_com_o
);

  localparam int CNT_W = DMA_XFER_ID_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DMA_DESC_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [DMA_XFER_ID_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DMA_XFER_ID_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DMA_DESC_DEPTH-1:0] done_q, done_d;
  logic [DMA_XFER_ID_W-1:0]  act_id_q;
  logic [DMA_LENGTH_W-1:0]   act_len_q;
  logic                      irq_qed_q, irq_com_q;

  logic [SRC_ADDR_W-1:0]     src_mem_q  [DMA_DESC_DEPTH];
  logic [DST_ADDR_W-1:0]     dst_mem_q  [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0]   xlen_mem_q [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0]   ylen_mem_q [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0]   sstr_mem_q [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0]   dstr_mem_q [DMA_DESC_DEPTH];

  logic cpl_fire;   // completion of the outstanding transfer
  logic recirc;     // cyclic completion: head is copied back to the tail
  logic push;       // CSR push accepted this cycle
  logic issue_hs;   // engine accepts the offered descriptor
  logic mem_we;

  logic [SRC_ADDR_W-1:0]   wsrc;
  logic [DST_ADDR_W-1:0]   wdst;
  logic [DMA_LENGTH_W-1:0] wxlen, wylen, wsstr, wdstr;

  // Handshake qualifiers; recirculation owns the write port, so a push is refused then
  always_comb begin
    cpl_fire      = (state_q == ST_ACTIVE) && xfer_cpl_i;
    recirc        = cpl_fire && chn_cyclic_i;
    desc_wr_rdy_o = (count_q != DEPTH_CNT) && !recirc;
    push          = desc_wr_vld_i && desc_wr_rdy_o;
    issue_hs      = (state_q == ST_ISSUE) && desc_rd_rdy_i;
    mem_we        = push || recirc;
  end

  // Write-data source: CSR fields on a push, head slot on a cyclic copy
  always_comb begin
    wsrc  = desc_src_addr_i;
    wdst  = desc_dst_addr_i;
    wxlen = desc_xlen_i;
    wylen = desc_ylen_i;
    wsstr = desc_src_strd_i;
    wdstr = desc_dst_strd_i;
    if (recirc) begin
      wsrc  = src_mem_q[rd_ptr_q];
      wdst  = dst_mem_q[rd_ptr_q];
      wxlen = xlen_mem_q[rd_ptr_q];
      wylen = ylen_mem_q[rd_ptr_q];
      wsstr = sstr_mem_q[rd_ptr_q];
      wdstr = dstr_mem_q[rd_ptr_q];
    end
  end

  // Descriptor storage; contents need no reset since occupancy is tracked by count
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      src_mem_q[wr_ptr_q]  <= wsrc;
      dst_mem_q[wr_ptr_q]  <= wdst;
      xlen_mem_q[wr_ptr_q] <= wxlen;
      ylen_mem_q[wr_ptr_q] <= wylen;
      sstr_mem_q[wr_ptr_q] <= wsstr;
      dstr_mem_q[wr_ptr_q] <= wdstr;
    end
  end

  // Next-state for the issue FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if ((count_q != '0) && chn_en_i) state_d = ST_ISSUE;
      ST_ISSUE:  if (desc_rd_rdy_i)               state_d = ST_ACTIVE;
      ST_ACTIVE: if (xfer_cpl_i)                  state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  // Pointer, occupancy and done-bitmap next values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    done_d   = done_q;
    if (mem_we) begin
      wr_ptr_d         = wr_ptr_q + 1'b1;
      done_d[wr_ptr_q] = 1'b0;
    end
    if (cpl_fire) begin
      rd_ptr_d         = rd_ptr_q + 1'b1;
      // Set after the clear so a full cyclic queue still reports the completion
      done_d[rd_ptr_q] = 1'b1;
    end
    if (push && !(cpl_fire && !chn_cyclic_i)) begin
      count_d = count_q + 1'b1;
    end else if (!push && cpl_fire && !chn_cyclic_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers, active-transfer status and interrupt pulses
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= '0;
      act_id_q  <= '0;
      act_len_q <= '0;
      irq_qed_q <= 1'b0;
      irq_com_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      irq_qed_q <= push;
      irq_com_q <= cpl_fire;
      if (issue_hs) begin
        act_id_q  <= rd_ptr_q;
        act_len_q <= xlen_mem_q[rd_ptr_q];
      end
    end
  end

  // Offered descriptor; fields are zeroed when nothing is offered
  always_comb begin
    desc_rd_vld_o      = (state_q == ST_ISSUE);
    desc_rd_id_o       = '0;
    desc_rd_src_addr_o = '0;
    desc_rd_dst_addr_o = '0;
    desc_rd_xlen_o     = '0;
    desc_rd_ylen_o     = '0;
    desc_rd_src_strd_o = '0;
    desc_rd_dst_strd_o = '0;
    if (desc_rd_vld_o) begin
      desc_rd_id_o       = rd_ptr_q;
      desc_rd_src_addr_o = src_mem_q[rd_ptr_q];
      desc_rd_dst_addr_o = dst_mem_q[rd_ptr_q];
      desc_rd_xlen_o     = xlen_mem_q[rd_ptr_q];
      desc_rd_ylen_o     = ylen_mem_q[rd_ptr_q];
      desc_rd_src_strd_o = sstr_mem_q[rd_ptr_q];
      desc_rd_dst_strd_o = dstr_mem_q[rd_ptr_q];
    end
  end

  assign xfer_id_o         = wr_ptr_q;
  assign xfer_done_o       = done_q;
  assign active_xfer_id_o  = act_id_q;
  assign active_xfer_len_o = act_len_q;
  assign irq_qed_o         = irq_qed_q;
  assign irq_com_o         = irq_com_q;

endmodule
`default_nettype wire

// File: tb/tb_adma_desc_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adma_desc_queue
//  Purpose  : Directed self-checking bench for adma_desc_queue with an issue
//             scoreboard and a small pointer/done-bitmap model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adma_desc_queue;

  logic        aclk = 1'b0;
  logic        areset;
  logic        chn_en_i, chn_cyclic_i;
  logic        desc_wr_vld_i, desc_wr_rdy_o;
  logic [31:0] desc_src_addr_i, desc_dst_addr_i;
  logic [15:0] desc_xlen_i, desc_ylen_i, desc_src_strd_i, desc_dst_strd_i;
  logic        desc_rd_vld_o, desc_rd_rdy_i;
  logic [1:0]  desc_rd_id_o;
  logic [31:0] desc_rd_src_addr_o, desc_rd_dst_addr_o;
  logic [15:0] desc_rd_xlen_o, desc_rd_ylen_o, desc_rd_src_strd_o, desc_rd_dst_strd_o;
  logic        xfer_cpl_i;
  logic [1:0]  xfer_id_o;
  logic [3:0]  xfer_done_o;
  logic [1:0]  active_xfer_id_o;
  logic [15:0] active_xfer_len_o;
  logic        irq_qed_o, irq_com_o;

  adma_desc_queue dut (
    .aclk               (aclk),
    .areset             (areset),
    .chn_en_i           (chn_en_i),
    .chn_cyclic_i       (chn_cyclic_i),
    .desc_wr_vld_i      (desc_wr_vld_i),
    .desc_wr_rdy_o      (desc_wr_rdy_o),
    .desc_src_addr_i    (desc_src_addr_i),
    .desc_dst_addr_i    (desc_dst_addr_i),
    .desc_xlen_i        (desc_xlen_i),
    .desc_ylen_i        (desc_ylen_i),
    .desc_src_strd_i    (desc_src_strd_i),
    .desc_dst_strd_i    (desc_dst_strd_i),
    .desc_rd_vld_o      (desc_rd_vld_o),
    .desc_rd_rdy_i      (desc_rd_rdy_i),
    .desc_rd_id_o       (desc_rd_id_o),
    .desc_rd_src_addr_o (desc_rd_src_addr_o),
    .desc_rd_dst_addr_o (desc_rd_dst_addr_o),
    .desc_rd_xlen_o     (desc_rd_xlen_o),
    .desc_rd_ylen_o     (desc_rd_ylen_o),
    .desc_rd_src_strd_o (desc_rd_src_strd_o),
    .desc_rd_dst_strd_o (desc_rd_dst_strd_o),
    .xfer_cpl_i         (xfer_cpl_i),
    .xfer_id_o          (xfer_id_o),
    .xfer_done_o        (xfer_done_o),
    .active_xfer_id_o   (active_xfer_id_o),
    .active_xfer_len_o  (active_xfer_len_o),
    .irq_qed_o          (irq_qed_o),
    .irq_com_o          (irq_com_o)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] xlen;
    logic [15:0] ylen;
    logic [15:0] sstr;
    logic [15:0] dstr;
  } desc_t;

  desc_t      sb[$];   // expected issue order
  desc_t      act;     // descriptor currently in flight
  logic [1:0] mwr;     // model write pointer
  logic [3:0] mdone;   // model done bitmap
  int         mcnt;    // model occupancy
  int         npass = 0;
  int         ntot  = 0;
  int         nfail = 0;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    mwr   = '0;
    mdone = '0;
    mcnt  = 0;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    chn_en_i      = 1'b0;
    chn_cyclic_i  = 1'b0;
    desc_wr_vld_i = 1'b0;
    desc_rd_rdy_i = 1'b0;
    xfer_cpl_i    = 1'b0;
    tick();
    areset = 1'b0;
    model_clear();
  endtask

  task automatic do_push(input string tag, input logic [31:0] src, input logic [15:0] xlen);
    desc_t e;
    int n = 0;
    e.src  = src;
    e.dst  = src ^ 32'h5A5A_0000;
    e.xlen = xlen;
    e.ylen = xlen ^ 16'h00FF;
    e.sstr = xlen + 16'd1;
    e.dstr = xlen + 16'd2;
    desc_src_addr_i = e.src;
    desc_dst_addr_i = e.dst;
    desc_xlen_i     = e.xlen;
    desc_ylen_i     = e.ylen;
    desc_src_strd_i = e.sstr;
    desc_dst_strd_i = e.dstr;
    desc_wr_vld_i   = 1'b1;
    while (!desc_wr_rdy_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_wr_rdy"}, 64'(desc_wr_rdy_o), 64'd1);
    if (!desc_wr_rdy_o) begin
      desc_wr_vld_i = 1'b0;
      return;
    end
    tick();
    desc_wr_vld_i = 1'b0;
    e.id = mwr;
    mdone[mwr] = 1'b0;
    mwr  = mwr + 2'd1;
    mcnt++;
    sb.push_back(e);
    chk({tag, "_irq_qed"}, 64'(irq_qed_o), 64'd1);
    chk({tag, "_xfer_id"}, 64'(xfer_id_o), 64'(mwr));
  endtask

  task automatic do_issue(input string tag);
    desc_t e;
    int n = 0;
    while (!desc_rd_vld_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rd_vld"}, 64'(desc_rd_vld_o), 64'd1);
    if (!desc_rd_vld_o) return;
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, "_rd_id"},   64'(desc_rd_id_o),       64'(e.id));
    chk({tag, "_rd_src"},  64'(desc_rd_src_addr_o), 64'(e.src));
    chk({tag, "_rd_dst"},  64'(desc_rd_dst_addr_o), 64'(e.dst));
    chk({tag, "_rd_xlen"}, 64'(desc_rd_xlen_o),     64'(e.xlen));
    chk({tag, "_rd_ylen"}, 64'(desc_rd_ylen_o),     64'(e.ylen));
    chk({tag, "_rd_strd"}, {32'd0, desc_rd_src_strd_o, desc_rd_dst_strd_o}, {32'd0, e.sstr, e.dstr});
    desc_rd_rdy_i = 1'b1;
    tick();
    desc_rd_rdy_i = 1'b0;
    act = e;
    chk({tag, "_act_id"},  64'(active_xfer_id_o),  64'(e.id));
    chk({tag, "_act_len"}, 64'(active_xfer_len_o), 64'(e.xlen));
    chk({tag, "_vld_low"}, 64'(desc_rd_vld_o),     64'd0);
  endtask

  task automatic do_complete(input string tag);
    desc_t c;
    xfer_cpl_i = 1'b1;
    #1;
    chk({tag, "_cpl_rdy"}, 64'(desc_wr_rdy_o), 64'((mcnt < 4) && !chn_cyclic_i));
    tick();
    xfer_cpl_i = 1'b0;
    if (chn_cyclic_i) begin
      c    = act;
      c.id = mwr;
      mdone[mwr] = 1'b0;
      mwr = mwr + 2'd1;
      sb.push_back(c);
    end else begin
      mcnt--;
    end
    mdone[act.id] = 1'b1;
    chk({tag, "_irq_com"}, 64'(irq_com_o),   64'd1);
    chk({tag, "_no_qed"},  64'(irq_qed_o),   64'd0);
    chk({tag, "_done"},    64'(xfer_done_o), 64'(mdone));
    chk({tag, "_xfer_id"}, 64'(xfer_id_o),   64'(mwr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    desc_src_addr_i = '0;
    desc_dst_addr_i = '0;
    desc_xlen_i     = '0;
    desc_ylen_i     = '0;
    desc_src_strd_i = '0;
    desc_dst_strd_i = '0;
    act             = '0;
    do_reset();
    do_reset();

    // Reset state
    chk("rst_wr_rdy",  64'(desc_wr_rdy_o),     64'd1);
    chk("rst_rd_vld",  64'(desc_rd_vld_o),     64'd0);
    chk("rst_xfer_id", 64'(xfer_id_o),         64'd0);
    chk("rst_done",    64'(xfer_done_o),       64'd0);
    chk("rst_act_len", 64'(active_xfer_len_o), 64'd0);
    chk("rst_irq",     {62'd0, irq_qed_o, irq_com_o}, 64'd0);

    // 1: single descriptor end to end
    chn_en_i = 1'b1;
    do_push("t1_push", 32'h1000_0000, 16'h0040);
    do_issue("t1_iss");
    do_complete("t1_cpl");
    tick();
    chk("t1_irq_com_once", 64'(irq_com_o), 64'd0);
    repeat (3) tick();
    chk("t1_empty_no_issue", 64'(desc_rd_vld_o), 64'd0);

    // 2: fill with engine disabled, stall the fifth push, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) do_push("t2_push", 32'h2000_0000 + 32'(i * 16), 16'(16'h0100 + i));
    chk("t2_full_rdy",  64'(desc_wr_rdy_o), 64'd0);
    chk("t2_wrap_id",   64'(xfer_id_o),     64'd0);
    desc_wr_vld_i = 1'b1;
    repeat (3) begin
      tick();
      chk("t2_stall_rdy", 64'(desc_wr_rdy_o), 64'd0);
      chk("t2_stall_qed", 64'(irq_qed_o),     64'd0);
    end
    desc_wr_vld_i = 1'b0;
    chk("t2_en_off_no_issue", 64'(desc_rd_vld_o), 64'd0);
    chn_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_issue("t2_iss");
      do_complete("t2_cpl");
    end

    // 3: cyclic re-queue of two descriptors
    do_reset();
    chn_cyclic_i = 1'b1;
    do_push("t3_push_a", 32'hAAAA_0000, 16'h0A0A);
    do_push("t3_push_b", 32'hBBBB_0000, 16'h0B0B);
    chn_en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_issue("t3_iss");
      do_complete("t3_cpl");
    end
    chk("t3_count_kept_rdy", 64'(desc_wr_rdy_o), 64'd1);

    // 4: full queue, push collides with completion
    do_reset();
    for (int i = 0; i < 4; i++) do_push("t4_push", 32'h4000_0000 + 32'(i), 16'(16'h0200 + i));
    chn_en_i = 1'b1;
    do_issue("t4_iss0");
    desc_src_addr_i = 32'h4444_7777;
    desc_dst_addr_i = 32'h4444_7777 ^ 32'h5A5A_0000;
    desc_xlen_i     = 16'h0077;
    desc_ylen_i     = 16'h0077 ^ 16'h00FF;
    desc_src_strd_i = 16'h0078;
    desc_dst_strd_i = 16'h0079;
    desc_wr_vld_i   = 1'b1;
    xfer_cpl_i      = 1'b1;
    #1;
    chk("t4_collide_rdy", 64'(desc_wr_rdy_o), 64'd0);
    tick();
    xfer_cpl_i = 1'b0;
    mdone[0] = 1'b1;
    mcnt--;
    chk("t4_collide_com",  64'(irq_com_o),     64'd1);
    chk("t4_collide_qed",  64'(irq_qed_o),     64'd0);
    chk("t4_collide_done", 64'(xfer_done_o),   64'(mdone));
    chk("t4_freed_rdy",    64'(desc_wr_rdy_o), 64'd1);
    tick();
    desc_wr_vld_i = 1'b0;
    sb.push_back('{id: mwr, src: 32'h4444_7777, dst: 32'h4444_7777 ^ 32'h5A5A_0000,
                   xlen: 16'h0077, ylen: 16'h0077 ^ 16'h00FF, sstr: 16'h0078, dstr: 16'h0079});
    mdone[mwr] = 1'b0;
    mwr = mwr + 2'd1;
    mcnt++;
    chk("t4_late_qed",  64'(irq_qed_o),   64'd1);
    chk("t4_late_done", 64'(xfer_done_o), 64'(mdone));
    chk("t4_late_id",   64'(xfer_id_o),   64'(mwr));
    for (int i = 0; i < 4; i++) begin
      do_issue("t4_iss");
      do_complete("t4_cpl");
    end

    // 5: reset while a transfer is active
    do_reset();
    for (int i = 0; i < 3; i++) do_push("t5_push", 32'h5000_0000 + 32'(i), 16'(16'h0300 + i));
    chn_en_i = 1'b1;
    do_issue("t5_iss");
    areset = 1'b1;
    tick();
    areset = 1'b0;
    model_clear();
    chk("t5_wr_rdy",  64'(desc_wr_rdy_o),      64'd1);
    chk("t5_rd_vld",  64'(desc_rd_vld_o),      64'd0);
    chk("t5_rd_src",  64'(desc_rd_src_addr_o), 64'd0);
    chk("t5_xfer_id", 64'(xfer_id_o),          64'd0);
    chk("t5_done",    64'(xfer_done_o),        64'd0);
    chk("t5_act",     {46'd0, active_xfer_id_o, active_xfer_len_o}, 64'd0);
    chk("t5_irq",     {62'd0, irq_qed_o, irq_com_o}, 64'd0);
    xfer_cpl_i = 1'b1;
    tick();
    xfer_cpl_i = 1'b0;
    chk("t5_stray_com",  64'(irq_com_o),     64'd0);
    chk("t5_stray_done", 64'(xfer_done_o),   64'd0);
    chk("t5_stray_vld",  64'(desc_rd_vld_o), 64'd0);

    // 6: completion pulses outside ACTIVE are ignored
    do_reset();
    xfer_cpl_i = 1'b1;
    tick();
    xfer_cpl_i = 1'b0;
    chk("t6_idle0_com",  64'(irq_com_o),     64'd0);
    chk("t6_idle0_rdy",  64'(desc_wr_rdy_o), 64'd1);
    do_push("t6_push", 32'h6000_0000, 16'h0600);
    xfer_cpl_i = 1'b1;
    tick();
    xfer_cpl_i = 1'b0;
    chk("t6_idle1_com",  64'(irq_com_o),   64'd0);
    chk("t6_idle1_done", 64'(xfer_done_o), 64'd0);
    chk("t6_idle1_id",   64'(xfer_id_o),   64'd1);
    chn_en_i = 1'b1;
    for (int i = 0; i < 20 && !desc_rd_vld_o; i++) tick();
    chk("t6_issue_vld", 64'(desc_rd_vld_o), 64'd1);
    chn_en_i   = 1'b0;
    xfer_cpl_i = 1'b1;
    tick();
    xfer_cpl_i = 1'b0;
    chk("t6_iss_vld_held", 64'(desc_rd_vld_o),      64'd1);
    chk("t6_iss_src_held", 64'(desc_rd_src_addr_o), 64'h6000_0000);
    chk("t6_iss_com",      64'(irq_com_o),          64'd0);
    chk("t6_iss_done",     64'(xfer_done_o),        64'd0);
    do_issue("t6_iss");
    do_complete("t6_cpl");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
